memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the single memory bus (ROM/RAM/peripherals/block RAM, 16-bit byte address, 32-bit data, 4-bit write mask) between two requesters.
- Requester 0 is the CPU core. Requester 1 is a DMA/loader engine.
- The block grants one requester at a time, drives the bus for a fixed number of cycles, captures read data and returns it with a one-cycle acknowledge.
- It sits between the requesters and memory_bus and is the only driver of memory_bus inputs.

Parameters:
- READ_LATENCY, 1, clk cycles from bus signals valid to mem_data_out valid; legal range 1..15.
- FAIR, 1, 1 = round-robin on ties; 0 = fixed priority, requester 0 always wins.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- req_0  input  1  requester 0 access request; held until ack_0
- wr_0  input  1  1 = write, 0 = read
- addr_0  input  16  byte address
- wdata_0  input  32  write data
- mask_0  input  4  byte write mask
- ack_0  output  1  one-cycle completion pulse
- rdata_0  output  32  read data, valid while ack_0=1
- req_1, wr_1, addr_1, wdata_1, mask_1, ack_1, rdata_1: same as requester 0, for requester 1
- mem_address  output  16  to memory_bus address
- mem_data_in  output  32  to memory_bus data_in
- mem_write_mask  output  4  to memory_bus write_mask
- mem_bus_enable  output  1  to memory_bus bus_enable
- mem_write_enable  output  1  to memory_bus write_enable
- mem_data_out  input  32  from memory_bus data_out
- busy  output  1  state != IDLE
- grant  output  1  index of the current/last granted requester

Behaviour:
- All outputs are registered. On reset: state=IDLE, all mem_* = 0, ack_0/ack_1 = 0, rdata_0/rdata_1 = 0, busy = 0, grant = 1, so requester 0 wins the first tie.
- States are IDLE, ACCESS and DONE.
- IDLE:
  - With no request, mem_bus_enable and mem_write_enable are 0 and the address/data outputs hold their last values.
  - If exactly one req is high, that requester is granted.
  - If both are high and FAIR=1, the requester != grant wins. If FAIR=0, requester 0 wins.
  - At the granting edge, the block latches addr/wdata/mask into mem_*, sets mem_bus_enable=1, sets mem_write_enable=wr, updates grant, clears cnt and enters ACCESS.
- ACCESS:
  - Lasts exactly READ_LATENCY cycles; cnt increments each cycle.
  - mem_bus_enable stays 1 for all ACCESS cycles.
  - mem_write_enable is 1 only in the first ACCESS cycle, so a write is performed once.
  - mem_address, mem_data_in and mem_write_mask are stable for the whole access. Requester inputs are ignored after the grant edge.
  - At the edge where cnt == READ_LATENCY-1: if the access is a read, mem_data_out is captured into rdata_<grant>; for a write, rdata is unchanged. The block then asserts ack_<grant>=1, clears mem_bus_enable and mem_write_enable, and enters DONE.
- DONE: ack is high for this one cycle only, then the block returns to IDLE with ack cleared. No grant is made in DONE.
- Latency: req sampled high in IDLE at edge N → ack high during cycle N+READ_LATENCY+1. Back-to-back period per access is READ_LATENCY+2 cycles.
- Requester rule: the requester drops req, or presents its next request, at the edge where it samples ack=1. A req still high in the following IDLE cycle is a new request.
- rdata_x holds its value until the next read completes for that requester.
- Simultaneous events:
  - A request arriving during ACCESS or DONE waits in IDLE; it is never lost because req is level-held.
  - With FAIR=1 and both requesters continuously requesting, grants strictly alternate 0,1,0,1.
- Reset mid-operation (any state): the block returns to the reset values on the next edge. No ack is issued for the aborted access. mem_write_enable drops immediately, so a write in its first ACCESS cycle may or may not have completed.
- Width rules: addresses and data pass through unchanged; no alignment checks. cnt is 4 bits.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2
  - memory bank constants for address[15:14]: RAM=00, ROM=01, PERIPH=10, BLOCK_RAM=11
  - width constants ADDR_W=16, DATA_W=32, MASK_W=4
- One sub-module is natural: rr_arbiter2, combinational winner selection from req_0, req_1, grant and FAIR.

Test Plan:
1. Single read, READ_LATENCY=1: req_0=1, wr_0=0, addr_0=16'h0010, memory returns 32'hDEADBEEF → mem_bus_enable=1 for 1 cycle with mem_address=16'h0010; ack_0 pulses 2 cycles after the req edge; rdata_0=32'hDEADBEEF; ack_1 stays 0.
2. Write once: READ_LATENCY=3, req_1=1, wr_1=1, addr_1=16'hC004, wdata_1=32'h12345678, mask_1=4'b0011 → mem_write_enable high exactly 1 cycle; bus_enable high 3 cycles; ack_1 at cycle 4; rdata_1 unchanged.
3. Contention with FAIR=1: req_0 and req_1 held for 4 accesses → grant order 0,1,0,1; each access takes 3 cycles at READ_LATENCY=1.
4. Fixed priority, FAIR=0: both requesters held → requester 0 always granted, requester 1 never acked while req_0 stays high.
5. Late arrival: req_1 rises during requester 0's ACCESS → serviced starting in the IDLE cycle after DONE; requester 0's ack is unaffected.
6. Reset in ACCESS, READ_LATENCY=3: reset asserted in the second ACCESS cycle → next cycle all mem_* = 0, busy = 0, no ack issued; after release a re-issued req completes normally.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and widths for the two-requester memory bus arbiter.
// Bank decode constants describe address[15:14] of the memory map.
package memory_arbiter_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      BANK_RAM       = 2'b00,
      BANK_ROM       = 2'b01,
      BANK_PERIPH    = 2'b10,
      BANK_BLOCK_RAM = 2'b11
   } bank_e;

endpackage

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Combinational two-way winner select: round-robin on ties when FAIR,
// otherwise requester 0 always wins.
module rr_arbiter2 #(
   parameter bit FAIR = 1'b1
) (
   input  logic req_0_i,
   input  logic req_1_i,
   input  logic last_grant_i,
   output logic valid_o,
   output logic winner_o
);

   always_comb begin
      valid_o  = req_0_i | req_1_i;
      winner_o = 1'b0;
      if (req_0_i && req_1_i) begin
         winner_o = FAIR ? ~last_grant_i : 1'b0;
      end else if (req_1_i) begin
         winner_o = 1'b1;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Grants one of two requesters the memory bus for READ_LATENCY cycles,
// captures read data and returns it with a one-cycle acknowledge.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned FAIR         = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_0,
   input  logic              wr_0,
   input  logic [ADDR_W-1:0] addr_0,
   input  logic [DATA_W-1:0] wdata_0,
   input  logic [MASK_W-1:0] mask_0,
   output logic              ack_0,
   output logic [DATA_W-1:0] rdata_0,
   input  logic              req_1,
   input  logic              wr_1,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [DATA_W-1:0] wdata_1,
   input  logic [MASK_W-1:0] mask_1,
   output logic              ack_1,
   output logic [DATA_W-1:0] rdata_1,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic [MASK_W-1:0] mem_write_mask,
   output logic              mem_bus_enable,
   output logic              mem_write_enable,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy,
   output logic              grant
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LATENCY - 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               grant_q;
   logic               wr_q;
   logic               busy_q;
   logic               bus_en_q;
   logic               we_q;
   logic               ack0_q;
   logic               ack1_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [MASK_W-1:0]  mask_q;
   logic [DATA_W-1:0]  rdata0_q;
   logic [DATA_W-1:0]  rdata1_q;

   logic               arb_valid;
   logic               arb_winner;
   logic               sel_wr;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic [MASK_W-1:0]  sel_mask;

   rr_arbiter2 #(
      .FAIR (FAIR != 0)
   ) u_arb (
      .req_0_i      (req_0),
      .req_1_i      (req_1),
      .last_grant_i (grant_q),
      .valid_o      (arb_valid),
      .winner_o     (arb_winner)
   );

   always_comb begin
      sel_wr    = arb_winner ? wr_1    : wr_0;
      sel_addr  = arb_winner ? addr_1  : addr_0;
      sel_wdata = arb_winner ? wdata_1 : wdata_0;
      sel_mask  = arb_winner ? mask_1  : mask_0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         grant_q  <= 1'b1;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         bus_en_q <= 1'b0;
         we_q     <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mask_q   <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  grant_q  <= arb_winner;
                  wr_q     <= sel_wr;
                  addr_q   <= sel_addr;
                  wdata_q  <= sel_wdata;
                  mask_q   <= sel_mask;
                  bus_en_q <= 1'b1;
                  we_q     <= sel_wr;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= ACCESS;
               end
            end
            ACCESS: begin
               // write strobe covers only the first access cycle
               we_q  <= 1'b0;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  if (!wr_q) begin
                     if (grant_q) rdata1_q <= mem_data_out;
                     else         rdata0_q <= mem_data_out;
                  end
                  if (grant_q) ack1_q <= 1'b1;
                  else         ack0_q <= 1'b1;
                  bus_en_q <= 1'b0;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack_0            = ack0_q;
   assign ack_1            = ack1_q;
   assign rdata_0          = rdata0_q;
   assign rdata_1          = rdata1_q;
   assign mem_address      = addr_q;
   assign mem_data_in      = wdata_q;
   assign mem_write_mask   = mask_q;
   assign mem_bus_enable   = bus_en_q;
   assign mem_write_enable = we_q;
   assign busy             = busy_q;
   assign grant            = grant_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: three instances (RL1 fair, RL3 fair, RL1 fixed)
// sharing one latency-checking memory model and an ack scoreboard.
module tb_memory_arbiter;

   localparam int NDUT = 3;

   function automatic int rl_of(input int k);
      return (k == 1) ? 3 : 1;
   endfunction

   function automatic int fair_of(input int k);
      return (k == 2) ? 0 : 1;
   endfunction

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        req0[NDUT], wr0[NDUT], req1[NDUT], wr1[NDUT];
   logic [15:0] addr0[NDUT], addr1[NDUT];
   logic [31:0] wdata0[NDUT], wdata1[NDUT];
   logic [3:0]  mask0[NDUT], mask1[NDUT];
   logic        ack0[NDUT], ack1[NDUT];
   logic [31:0] rdata0[NDUT], rdata1[NDUT];
   logic [15:0] maddr[NDUT];
   logic [31:0] mdin[NDUT], mdout[NDUT];
   logic [3:0]  mmask[NDUT];
   logic        bus_en[NDUT], we[NDUT], busy[NDUT], grant[NDUT];
   int unsigned en_cnt[NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      memory_arbiter #(
         .READ_LATENCY (rl_of(g)),
         .FAIR         (fair_of(g))
      ) u_dut (
         .clk              (clk),
         .reset            (reset),
         .req_0            (req0[g]),
         .wr_0             (wr0[g]),
         .addr_0           (addr0[g]),
         .wdata_0          (wdata0[g]),
         .mask_0           (mask0[g]),
         .ack_0            (ack0[g]),
         .rdata_0          (rdata0[g]),
         .req_1            (req1[g]),
         .wr_1             (wr1[g]),
         .addr_1           (addr1[g]),
         .wdata_1          (wdata1[g]),
         .mask_1           (mask1[g]),
         .ack_1            (ack1[g]),
         .rdata_1          (rdata1[g]),
         .mem_address      (maddr[g]),
         .mem_data_in      (mdin[g]),
         .mem_write_mask   (mmask[g]),
         .mem_bus_enable   (bus_en[g]),
         .mem_write_enable (we[g]),
         .mem_data_out     (mdout[g]),
         .busy             (busy[g]),
         .grant            (grant[g])
      );
   end

   // Memory image: unwritten words read as {~addr, addr}.
   logic [31:0] mem_img [logic [15:0]];

   function automatic logic [31:0] mem_rd(input logic [15:0] a);
      if (mem_img.exists(a)) return mem_img[a];
      return {~a, a};
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         en_cnt[k] <= bus_en[k] ? en_cnt[k] + 1 : 0;
         if (we[k]) begin
            logic [31:0] w;
            w = mem_rd(maddr[k]);
            for (int b = 0; b < 4; b++)
               if (mmask[k][b]) w[8*b +: 8] = mdin[k][8*b +: 8];
            mem_img[maddr[k]] = w;
         end
      end
   end

   // Data is valid only on the cycle the RL-th sample happens.
   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++)
         mdout[k] = (bus_en[k] && en_cnt[k] == rl_of(k) - 1) ? mem_rd(maddr[k]) : 32'hBAD0BAD0;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      int          dut;
      int          r;
      logic [31:0] rdata;
   } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         if (ack0[k] || ack1[k]) begin
            exp_t e;
            chk("single ack", {31'b0, ack0[k] & ack1[k]}, 32'd0);
            if (sb.size() == 0) begin
               chk("stray ack", {31'b0, ack0[k] | ack1[k]}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack dut", k, e.dut);
               chk("ack requester", {31'b0, ack1[k]}, e.r);
               chk("rdata", ack1[k] ? rdata1[k] : rdata0[k], e.rdata);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input int r, input logic w, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      if (r == 0) begin
         req0[k] = 1'b1; wr0[k] = w; addr0[k] = a; wdata0[k] = d; mask0[k] = m;
      end else begin
         req1[k] = 1'b1; wr1[k] = w; addr1[k] = a; wdata1[k] = d; mask1[k] = m;
      end
   endtask

   task automatic drop(input int k, input int r);
      if (r == 0) req0[k] = 1'b0;
      else        req1[k] = 1'b0;
   endtask

   task automatic xact(input int k, input int r, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic [31:0] exp_rd);
      int n;
      bit seen;
      sb.push_back(exp_t'{k, r, exp_rd});
      drive(k, r, w, a, d, m);
      step();
      chk("grant busy", busy[k], 1);
      chk("grant index", grant[k], r);
      chk("grant bus_en", bus_en[k], 1);
      chk("grant write_en", we[k], w);
      chk("grant address", maddr[k], a);
      if (w) begin
         chk("grant wdata", mdin[k], d);
         chk("grant mask", mmask[k], m);
      end
      drive(k, r, ~w, ~a, ~d, ~m);
      n = 0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         n++;
         if ((r == 0) ? ack0[k] : ack1[k]) seen = 1;
         else begin
            chk("hold bus_en", bus_en[k], 1);
            chk("write once", we[k], 0);
            chk("address stable", maddr[k], a);
         end
      end
      chk("ack seen", seen, 1);
      chk("ack latency", n, rl_of(k));
      drop(k, r);
      chk("done bus_en", bus_en[k], 0);
      chk("done write_en", we[k], 0);
      chk("done busy", busy[k], 1);
      step();
      chk("idle busy", busy[k], 0);
      chk("ack one cycle", (r == 0) ? ack0[k] : ack1[k], 0);
   endtask

   typedef struct {
      int          dut;
      int          r;
      logic        w;
      logic [15:0] a;
      logic [31:0] d;
      logic [3:0]  m;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t tbl[9];

   initial begin
      int acks, last, a0, a1, t0, t1;

      tbl[0] = vec_t'{0, 0, 1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF};
      tbl[1] = vec_t'{1, 1, 1'b1, 16'hC004, 32'h12345678, 4'h3, 32'h00000000};
      tbl[2] = vec_t'{1, 1, 1'b0, 16'hC004, 32'h0,        4'h0, 32'h3FFB5678};
      tbl[3] = vec_t'{1, 0, 1'b0, 16'h4000, 32'h0,        4'h0, 32'hBFFF4000};
      tbl[4] = vec_t'{0, 1, 1'b1, 16'h8008, 32'hAABBCCDD, 4'hC, 32'h00000000};
      tbl[5] = vec_t'{0, 1, 1'b0, 16'h8008, 32'h0,        4'h0, 32'hAABB8008};
      tbl[6] = vec_t'{2, 1, 1'b0, 16'h0020, 32'h0,        4'h0, 32'hFFDF0020};
      tbl[7] = vec_t'{1, 0, 1'b1, 16'h0010, 32'h00000000, 4'hF, 32'hBFFF4000};
      tbl[8] = vec_t'{0, 0, 1'b0, 16'h0010, 32'h0,        4'h0, 32'h00000000};

      mem_img[16'h0010] = 32'hDEADBEEF;
      for (int k = 0; k < NDUT; k++) begin
         req0[k] = 0; wr0[k] = 0; addr0[k] = '0; wdata0[k] = '0; mask0[k] = '0;
         req1[k] = 0; wr1[k] = 0; addr1[k] = '0; wdata1[k] = '0; mask1[k] = '0;
      end
      reset = 1'b1;
      repeat (3) step();
      for (int k = 0; k < NDUT; k++) begin
         chk("reset busy", busy[k], 0);
         chk("reset grant", grant[k], 1);
         chk("reset bus_en", bus_en[k], 0);
         chk("reset write_en", we[k], 0);
         chk("reset address", maddr[k], 0);
         chk("reset ack0", ack0[k], 0);
         chk("reset rdata1", rdata1[k], 0);
      end
      reset = 1'b0;
      step();

      for (int v = 0; v < 9; v++)
         xact(tbl[v].dut, tbl[v].r, tbl[v].w, tbl[v].a, tbl[v].d, tbl[v].m, tbl[v].exp_rd);

      // Round-robin contention on instance 0: last grant was 0, so 1 goes first.
      sb.push_back(exp_t'{0, 1, 32'hFDFF0200});
      sb.push_back(exp_t'{0, 0, 32'hFEFF0100});
      sb.push_back(exp_t'{0, 1, 32'hFDFF0200});
      sb.push_back(exp_t'{0, 0, 32'hFEFF0100});
      drive(0, 0, 1'b0, 16'h0100, 32'h0, 4'h0);
      drive(0, 1, 1'b0, 16'h0200, 32'h0, 4'h0);
      acks = 0;
      last = -1;
      for (int i = 0; i < 40 && acks < 4; i++) begin
         step();
         if (ack0[0] || ack1[0]) begin
            acks++;
            if (last >= 0) chk("rr period", i - last, 3);
            last = i;
            if (acks == 4) begin
               req0[0] = 0;
               req1[0] = 0;
            end
         end
      end
      chk("rr ack count", acks, 4);
      step();
      chk("rr back to idle", busy[0], 0);

      // Fixed priority on instance 2: requester 1 waits until requester 0 lets go.
      for (int i = 0; i < 3; i++) sb.push_back(exp_t'{2, 0, 32'hFCFF0300});
      sb.push_back(exp_t'{2, 1, 32'hFBFF0400});
      drive(2, 0, 1'b0, 16'h0300, 32'h0, 4'h0);
      drive(2, 1, 1'b0, 16'h0400, 32'h0, 4'h0);
      a0 = 0;
      a1 = 0;
      for (int i = 0; i < 40 && a1 == 0; i++) begin
         step();
         if (ack0[2]) begin
            a0++;
            if (a0 == 3) req0[2] = 0;
         end
         if (ack1[2]) begin
            a1++;
            req1[2] = 0;
         end
      end
      chk("fixed req0 acks", a0, 3);
      chk("fixed req1 acks", a1, 1);
      step();

      // Late arrival on instance 1 (RL=3): req_1 rises during requester 0's access.
      sb.push_back(exp_t'{1, 0, 32'hFAFF0500});
      sb.push_back(exp_t'{1, 1, 32'hF9FF0600});
      drive(1, 0, 1'b0, 16'h0500, 32'h0, 4'h0);
      step();
      drive(1, 1, 1'b0, 16'h0600, 32'h0, 4'h0);
      t0 = -1;
      t1 = -1;
      for (int i = 1; i < 30 && t1 < 0; i++) begin
         step();
         if (ack0[1]) begin
            t0 = i;
            req0[1] = 0;
         end
         if (ack1[1]) begin
            t1 = i;
            req1[1] = 0;
         end
      end
      chk("late req0 ack time", t0, 3);
      chk("late req1 after req0", t1 - t0, 5);
      step();

      // Reset in the second ACCESS cycle of instance 1.
      drive(1, 0, 1'b0, 16'h0700, 32'h0, 4'h0);
      step();
      step();
      chk("pre-reset busy", busy[1], 1);
      reset = 1'b1;
      step();
      chk("abort bus_en", bus_en[1], 0);
      chk("abort address", maddr[1], 0);
      chk("abort busy", busy[1], 0);
      chk("abort grant", grant[1], 1);
      chk("abort ack0", ack0[1], 0);
      chk("abort rdata0", rdata0[1], 0);
      req0[1] = 0;
      step();
      reset = 1'b0;
      step();
      chk("post-reset no ack", ack0[1], 0);
      xact(1, 0, 1'b0, 16'h0700, 32'h0, 4'h0, 32'hF8FF0700);

      repeat (3) step();
      chk("scoreboard drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
